// File: rtl/background_tile_fetch.sv
// Background tile fetch: maps each raster pixel to a word read from the
// 64x32-bit background index memory and extracts that pixel's 4-bit tile
// index. Fixed 3-cycle latency at one pixel per cycle, no stalls.
module background_tile_fetch #(
    parameter int unsigned TILE_W = 20,
    parameter int unsigned TILE_H = 30,
    parameter int unsigned COLS   = 32,
    parameter int unsigned ROWS   = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic        pix_sol,
    input  logic [4:0]  scroll_col,
    output logic [5:0]  mem_address,
    output logic        mem_chipselect,
    output logic        mem_clken,
    output logic        mem_write,
    output logic        mem_debugaccess,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    output logic        tile_valid,
    output logic [3:0]  tile_index,
    output logic [4:0]  tile_px_x,
    output logic [4:0]  tile_px_y
);

    localparam logic [4:0] XLast   = 5'(TILE_W - 1);
    localparam logic [4:0] YLast   = 5'(TILE_H - 1);
    localparam logic [4:0] ColLast = 5'(COLS - 1);
    localparam logic [3:0] RowLast = 4'(ROWS - 1);

    // Coordinates of the most recently accepted pixel
    logic [4:0] x_sub_q, x_sub_d;
    logic [4:0] col_q, col_d;
    logic [4:0] y_sub_q, y_sub_d;
    logic [3:0] row_q, row_d;
    logic [4:0] scroll_q, scroll_d;
    logic       synced_q, synced_d;
    logic       accept;
    logic [4:0] ecol;

    // Stage 1: read request plus delayed pixel attributes
    logic [5:0] addr_q;
    logic       cs_q;
    logic [2:0] nib_s1_q;
    logic [4:0] px_s1_q, py_s1_q;

    // Stage 2: aligned with mem_readdata
    logic       v_s2_q;
    logic [2:0] nib_s2_q;
    logic [4:0] px_s2_q, py_s2_q;

    // Stage 3: output registers
    logic       tv_q;
    logic [3:0] idx_q;
    logic [4:0] tx_q, ty_q;

    // Next coordinates for the pixel presented this cycle; sof dominates sol
    always_comb begin
        x_sub_d  = x_sub_q;
        col_d    = col_q;
        y_sub_d  = y_sub_q;
        row_d    = row_q;
        scroll_d = scroll_q;
        synced_d = synced_q;
        accept   = 1'b0;
        if (pix_valid && pix_sof) begin
            x_sub_d  = '0;
            col_d    = '0;
            y_sub_d  = '0;
            row_d    = '0;
            scroll_d = scroll_col;
            synced_d = 1'b1;
            accept   = 1'b1;
        end else if (pix_valid && synced_q) begin
            accept = 1'b1;
            if (pix_sol) begin
                x_sub_d = '0;
                col_d   = '0;
                if (y_sub_q == YLast) begin
                    y_sub_d = '0;
                    row_d   = (row_q == RowLast) ? 4'd0 : row_q + 4'd1;
                end else begin
                    y_sub_d = y_sub_q + 5'd1;
                end
            end else begin
                if (x_sub_q == XLast) begin
                    x_sub_d = '0;
                    col_d   = (col_q == ColLast) ? 5'd0 : col_q + 5'd1;
                end else begin
                    x_sub_d = x_sub_q + 5'd1;
                end
            end
        end
    end

    // 5-bit add wraps naturally modulo 32
    assign ecol = col_d + scroll_d;

    // Raster counters, latched scroll and sync flag
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            x_sub_q  <= '0;
            col_q    <= '0;
            y_sub_q  <= '0;
            row_q    <= '0;
            scroll_q <= '0;
            synced_q <= 1'b0;
        end else begin
            x_sub_q  <= x_sub_d;
            col_q    <= col_d;
            y_sub_q  <= y_sub_d;
            row_q    <= row_d;
            scroll_q <= scroll_d;
            synced_q <= synced_d;
        end
    end

    // Stage 1: issue the word read; address holds while idle
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            addr_q   <= '0;
            cs_q     <= 1'b0;
            nib_s1_q <= '0;
            px_s1_q  <= '0;
            py_s1_q  <= '0;
        end else begin
            cs_q <= accept;
            if (accept) begin
                addr_q   <= {row_d, ecol[4:3]};
                nib_s1_q <= ecol[2:0];
                px_s1_q  <= x_sub_d;
                py_s1_q  <= y_sub_d;
            end
        end
    end

    // Stage 2: delay attributes to line up with the returned word
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            v_s2_q   <= 1'b0;
            nib_s2_q <= '0;
            px_s2_q  <= '0;
            py_s2_q  <= '0;
        end else begin
            v_s2_q   <= cs_q;
            nib_s2_q <= nib_s1_q;
            px_s2_q  <= px_s1_q;
            py_s2_q  <= py_s1_q;
        end
    end

    // Stage 3: nibble extract; outputs hold while tile_valid is low
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            tv_q  <= 1'b0;
            idx_q <= '0;
            tx_q  <= '0;
            ty_q  <= '0;
        end else begin
            tv_q <= v_s2_q;
            if (v_s2_q) begin
                idx_q <= mem_readdata[{nib_s2_q, 2'b00} +: 4];
                tx_q  <= px_s2_q;
                ty_q  <= py_s2_q;
            end
        end
    end

    assign mem_address     = addr_q;
    assign mem_chipselect  = cs_q;
    assign mem_clken       = 1'b1;
    assign mem_write       = 1'b0;
    assign mem_debugaccess = 1'b0;
    assign mem_byteenable  = 4'hF;
    assign mem_writedata   = '0;
    assign tile_valid      = tv_q;
    assign tile_index      = idx_q;
    assign tile_px_x       = tx_q;
    assign tile_px_y       = ty_q;

endmodule

// File: tb/tb_background_tile_fetch.sv
// Randomized and directed bench for background_tile_fetch against a
// coordinate-arithmetic reference model and a simple s1 memory model.
module tb_background_tile_fetch;

    localparam int TW = 20;
    localparam int TH = 30;

    logic        clk_clk;
    logic        reset_reset;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_sol;
    logic [4:0]  scroll_col;
    logic [5:0]  mem_address;
    logic        mem_chipselect;
    logic        mem_clken;
    logic        mem_write;
    logic        mem_debugaccess;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        tile_valid;
    logic [3:0]  tile_index;
    logic [4:0]  tile_px_x;
    logic [4:0]  tile_px_y;

    background_tile_fetch dut (
        .clk_clk         (clk_clk),
        .reset_reset     (reset_reset),
        .pix_valid       (pix_valid),
        .pix_sof         (pix_sof),
        .pix_sol         (pix_sol),
        .scroll_col      (scroll_col),
        .mem_address     (mem_address),
        .mem_chipselect  (mem_chipselect),
        .mem_clken       (mem_clken),
        .mem_write       (mem_write),
        .mem_debugaccess (mem_debugaccess),
        .mem_byteenable  (mem_byteenable),
        .mem_writedata   (mem_writedata),
        .mem_readdata    (mem_readdata),
        .tile_valid      (tile_valid),
        .tile_index      (tile_index),
        .tile_px_x       (tile_px_x),
        .tile_px_y       (tile_px_y)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    // s1 memory: registered read, one cycle after the address
    logic [31:0] mem_words [64];
    always @(posedge clk_clk) mem_readdata <= mem_words[mem_address];

    typedef struct {
        int due;
        int addr;
        int idx;
        int xs;
        int ys;
    } exp_t;

    exp_t rd_q[$];
    exp_t out_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model state: raster position in plain pixel/line counts
    bit synced = 0;
    int px = 0;
    int line = 0;
    int scroll = 0;
    bit rst_pending = 0;

    // Last values the DUT must hold while idle
    int last_addr = 0;
    int last_idx = 0;
    int last_x = 0;
    int last_y = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_pixel(input bit sof, input bit sol, input int sc);
        exp_t e;
        int col, row, ecol, nib;
        if (sof) begin
            synced = 1;
            px = 0;
            line = 0;
            scroll = sc;
        end else if (!synced) begin
            return;
        end else if (sol) begin
            px = 0;
            line++;
        end else begin
            px++;
        end
        col  = (px / TW) % 32;
        row  = (line / TH) % 16;
        ecol = (col + scroll) % 32;
        nib  = ecol % 8;
        e.addr = row * 4 + ecol / 8;
        e.idx  = int'((mem_words[e.addr] >> (4 * nib)) & 32'hF);
        e.xs   = px % TW;
        e.ys   = line % TH;
        e.due  = cyc + 1;
        rd_q.push_back(e);
        e.due  = cyc + 3;
        out_q.push_back(e);
    endtask

    // One cycle: check outputs at the negedge, then drive the next inputs
    task automatic step(input bit rst, input bit v, input bit sof, input bit sol,
                        input logic [4:0] sc);
        bit exp_cs, exp_tv;
        @(negedge clk_clk);
        cyc++;
        if (rst_pending) begin
            last_addr = 0;
            last_idx = 0;
            last_x = 0;
            last_y = 0;
            rst_pending = 0;
        end
        exp_cs = 0;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            exp_cs = 1;
            last_addr = rd_q[0].addr;
            void'(rd_q.pop_front());
        end
        exp_tv = 0;
        if (out_q.size() > 0 && out_q[0].due == cyc) begin
            exp_tv = 1;
            last_idx = out_q[0].idx;
            last_x = out_q[0].xs;
            last_y = out_q[0].ys;
            void'(out_q.pop_front());
        end
        check("chipselect", 32'(mem_chipselect), 32'(exp_cs));
        check("address", 32'(mem_address), 32'(last_addr));
        check("tile_valid", 32'(tile_valid), 32'(exp_tv));
        check("tile_index", 32'(tile_index), 32'(last_idx));
        check("tile_px_x", 32'(tile_px_x), 32'(last_x));
        check("tile_px_y", 32'(tile_px_y), 32'(last_y));
        check("const", {mem_clken, mem_write, mem_debugaccess, mem_byteenable},
              {1'b1, 1'b0, 1'b0, 4'hF});
        check("writedata", mem_writedata, 32'h0);

        reset_reset = rst;
        pix_valid = v;
        pix_sof = sof;
        pix_sol = sol;
        scroll_col = sc;
        if (rst) begin
            synced = 0;
            rd_q.delete();
            out_q.delete();
            rst_pending = 1;
        end else if (v) begin
            model_pixel(sof, sol, int'(sc));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 5'($urandom));
    endtask

    initial begin
        mem_words[0] = 32'h76543210;
        mem_words[1] = 32'hFEDCBA98;
        for (int i = 2; i < 64; i++) mem_words[i] = $urandom;

        reset_reset = 1;
        pix_valid = 0;
        pix_sof = 0;
        pix_sol = 0;
        scroll_col = 0;
        repeat (2) @(posedge clk_clk);

        // Reset, then unsynced pixels must be dropped
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, (i == 4), 0);
        idle(4);

        // First line, scroll 0
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 319; i++) step(0, 1, 0, 0, 0);
        idle(4);

        // Scroll 3 at sof; change to 7 mid-frame must be ignored
        step(0, 1, 1, 0, 3);
        for (int i = 0; i < 200; i++) step(0, 1, 0, 0, (i < 50) ? 5'd3 : 5'd7);
        step(0, 1, 0, 1, 7);
        for (int i = 0; i < 30; i++) step(0, 1, 0, 0, 7);
        idle(4);

        // Row change and full-frame wrap, scroll 31
        step(0, 1, 1, 0, 31);
        step(0, 1, 0, 0, 0);
        for (int l = 1; l <= 482; l++) begin
            step(0, 1, 0, 1, 0);
            step(0, 1, 0, 0, 0);
        end
        idle(4);

        // sof+sol together followed by gappy stream
        step(0, 1, 1, 1, 5);
        for (int i = 0; i < 60; i++) step(0, i[0], 0, (i == 30), 5'($urandom));
        idle(4);

        // Reset with three pixels in flight
        step(0, 1, 1, 0, 2);
        step(0, 1, 0, 0, 2);
        step(0, 1, 0, 0, 2);
        step(0, 1, 0, 0, 2);
        step(1, 1, 0, 0, 2);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 2);
        step(0, 1, 1, 0, 9);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 9);
        idle(4);

        // Randomized stream; strobes are randomized even on invalid cycles
        for (int i = 0; i < 4000; i++) begin
            bit v, sof, sol;
            v   = ($urandom_range(3) != 0);
            sof = ($urandom_range(299) == 0);
            sol = ($urandom_range(24) == 0);
            step(($urandom_range(999) == 0), v, sof, sol, 5'($urandom));
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
